// File: rtl/btb_assoc_pkg.sv
// Shared types and defaults for the set-associative branch target buffer.
// Provides the LC-3b machine word type, the 2-bit direction counter type,
// default BTB geometry and the saturating counter step helper.
package btb_assoc_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  btb_ctr_t;

    localparam int BTB_WAYS = 4;
    localparam int BTB_SETS = 32;

    // Freshly allocated branches start weakly taken.
    localparam btb_ctr_t CTR_WEAK_TAKEN = 2'b10;

    // Saturating up/down step of a 2-bit direction counter.
    function automatic btb_ctr_t ctr_step(input btb_ctr_t ctr, input logic taken);
        btb_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Combinational tree pseudo-LRU helper for one set.
// Node 0 is the root, children of node n are 2n+1 (lower half) and 2n+2
// (upper half). A node bit of 0 steers the victim search to the lower half.
// Ports:
//   plru_i      - current PLRU bits of the set
//   touch_way_i - way being accessed
//   victim_o    - way the current bits point at
//   plru_o      - PLRU bits after touching touch_way_i
module btb_plru #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru_i,
    input  logic [WAY_W-1:0] touch_way_i,
    output logic [WAY_W-1:0] victim_o,
    output logic [WAYS-2:0]  plru_o
);

    // Walk from the root following the stored bits; each bit is one
    // address bit of the victim, most significant first.
    always_comb begin : victim_walk
        int   v_node;
        logic v_bit;
        victim_o = '0;
        v_node   = 0;
        for (int l = 0; l < WAY_W; l++) begin
            v_bit = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == v_node) v_bit = plru_i[n];
            end
            victim_o[WAY_W-1-l] = v_bit;
            v_node = 2 * v_node + 1 + (v_bit ? 1 : 0);
        end
    end

    // Walk the touched way's path and make every node point away from it.
    always_comb begin : touch_walk
        int   t_node;
        logic t_dir;
        plru_o = plru_i;
        t_node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            t_dir = touch_way_i[WAY_W-1-l];
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == t_node) plru_o[n] = ~t_dir;
            end
            t_node = 2 * t_node + 1 + (t_dir ? 1 : 0);
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters and
// tree pseudo-LRU replacement. Lookups are registered (1-cycle latency,
// read-before-write against the update port); resolved branches train the
// buffer through a single update port; flush invalidates every entry.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   lookup_valid, lookup_pc        - fetch-stage lookup request
//   pred_valid/hit/taken/target    - registered prediction
//   upd_valid/pc/target/taken      - resolved branch training
//   flush                          - synchronous invalidate of all entries
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int WAYS = BTB_WAYS,
    parameter int SETS = BTB_SETS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_valid,
    input  logic [15:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 15 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    // Control state (reset) and payload storage (not reset).
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAYS-2:0]  plru_q   [SETS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    lc3b_word         target_q [SETS][WAYS];
    btb_ctr_t         ctr_q    [SETS][WAYS];

    logic     pred_valid_q, pred_valid_d;
    logic     pred_hit_q,   pred_hit_d;
    logic     pred_taken_q, pred_taken_d;
    lc3b_word pred_target_q, pred_target_d;

    // Address split; bit 0 of the PC is ignored.
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    assign lk_idx  = lookup_pc[IDX_W:1];
    assign lk_tag  = lookup_pc[15:IDX_W+1];
    assign upd_idx = upd_pc[IDX_W:1];
    assign upd_tag = upd_pc[15:IDX_W+1];

    // Parallel tag compare across the ways of both indexed sets.
    logic [WAYS-1:0] lk_match, upd_match;
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
        assign lk_match[gi]  = valid_q[lk_idx][gi]  && (tag_q[lk_idx][gi]  == lk_tag);
        assign upd_match[gi] = valid_q[upd_idx][gi] && (tag_q[upd_idx][gi] == upd_tag);
    end

    // Lowest-numbered way wins for matches and for invalid-first allocation.
    logic             lk_hit, upd_hit, any_inv;
    logic [WAY_W-1:0] lk_way, upd_hit_way, inv_way;
    logic [WAYS-1:0]  upd_inv;
    assign upd_inv = ~valid_q[upd_idx];

    always_comb begin
        lk_hit      = |lk_match;
        upd_hit     = |upd_match;
        any_inv     = |upd_inv;
        lk_way      = '0;
        upd_hit_way = '0;
        inv_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w])  lk_way      = WAY_W'(w);
            if (upd_match[w]) upd_hit_way = WAY_W'(w);
            if (upd_inv[w])   inv_way     = WAY_W'(w);
        end
    end

    // Replacement: the victim depends only on the stored bits, so feeding
    // the chosen way back as the touch way forms no combinational loop.
    logic [WAY_W-1:0] plru_victim, upd_way;
    logic [WAYS-2:0]  plru_next;

    assign upd_way = upd_hit ? upd_hit_way : (any_inv ? inv_way : plru_victim);

    btb_plru #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_plru (
        .plru_i      (plru_q[upd_idx]),
        .touch_way_i (upd_way),
        .victim_o    (plru_victim),
        .plru_o      (plru_next)
    );

    // Not-taken misses change nothing; flush drops any concurrent update.
    logic upd_we;
    assign upd_we = upd_valid && !flush && (upd_hit || upd_taken);

    always_comb begin
        pred_valid_d  = lookup_valid;
        pred_hit_d    = lookup_valid && lk_hit;
        pred_taken_d  = pred_hit_d && ctr_q[lk_idx][lk_way][1];
        pred_target_d = pred_hit_d ? target_q[lk_idx][lk_way] : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 16'h0000;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (upd_we) begin
            valid_q[upd_idx][upd_way] <= 1'b1;
            plru_q[upd_idx]           <= plru_next;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_we) begin
            tag_q[upd_idx][upd_way] <= upd_tag;
            if (upd_taken) target_q[upd_idx][upd_way] <= upd_target;
            ctr_q[upd_idx][upd_way] <= upd_hit ? ctr_step(ctr_q[upd_idx][upd_way], upd_taken)
                                               : CTR_WEAK_TAKEN;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (WAYS=4, SETS=32): directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [15:0] lookup_pc;
    logic        pred_valid, pred_hit, pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid;
    logic [15:0] upd_pc, upd_target;
    logic        upd_taken;
    logic        flush;

    btb_assoc #(.WAYS(4), .SETS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .pred_valid   (pred_valid),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Behavioural model: each set holds 4 entries; replacement is a binary
    // tree where each node remembers which half to evict from next.
    bit m_valid [32][4];
    int m_tag   [32][4];
    int m_tgt   [32][4];
    int m_ctr   [32][4];
    bit m_node  [32][3];   // 0 = evict from lower half, 1 = upper half

    bit exp_valid, exp_hit, exp_taken;
    int exp_target;

    function automatic void model_clear();
        for (int s = 0; s < 32; s++) begin
            for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
            for (int n = 0; n < 3; n++) m_node[s][n] = 0;
        end
    endfunction

    function automatic int find(input int s, input int t);
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int victim(input int s);
        int lo = 0, size = 4, node = 0;
        while (size > 1) begin
            size = size / 2;
            if (m_node[s][node]) begin lo += size; node = 2 * node + 2; end
            else node = 2 * node + 1;
        end
        return lo;
    endfunction

    function automatic void touch(input int s, input int w);
        int lo = 0, size = 4, node = 0;
        while (size > 1) begin
            size = size / 2;
            if (w < lo + size) begin m_node[s][node] = 1; node = 2 * node + 1; end
            else begin m_node[s][node] = 0; lo += size; node = 2 * node + 2; end
        end
    endfunction

    // Called at each rising edge with the inputs sampled there.
    function automatic void model_edge();
        int s, t, w;
        exp_valid = 0; exp_hit = 0; exp_taken = 0; exp_target = 0;
        if (!rst_n) return;
        if (lookup_valid) begin
            exp_valid = 1;
            s = (lookup_pc >> 1) % 32;
            t = lookup_pc >> 6;
            w = find(s, t);
            if (w >= 0) begin
                exp_hit    = 1;
                exp_taken  = (m_ctr[s][w] >= 2);
                exp_target = m_tgt[s][w];
            end
        end
        if (flush) begin
            model_clear();
        end else if (upd_valid) begin
            s = (upd_pc >> 1) % 32;
            t = upd_pc >> 6;
            w = find(s, t);
            if (w >= 0) begin
                m_ctr[s][w] = upd_taken ? (m_ctr[s][w] == 3 ? 3 : m_ctr[s][w] + 1)
                                        : (m_ctr[s][w] == 0 ? 0 : m_ctr[s][w] - 1);
                if (upd_taken) m_tgt[s][w] = upd_target;
                touch(s, w);
            end else if (upd_taken) begin
                w = -1;
                for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) w = i;
                if (w < 0) w = victim(s);
                m_valid[s][w] = 1;
                m_tag[s][w]   = t;
                m_tgt[s][w]   = upd_target;
                m_ctr[s][w]   = 2;
                touch(s, w);
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("pred_valid",  pred_valid,  exp_valid);
        check("pred_hit",    pred_hit,    exp_hit);
        check("pred_taken",  pred_taken,  exp_taken);
        check("pred_target", pred_target, exp_target[15:0]);
    endtask

    task automatic op(input bit lv, input logic [15:0] lpc, input bit uv,
                      input logic [15:0] upc, input logic [15:0] utgt,
                      input bit utk, input bit fl);
        lookup_valid = lv; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk;
        flush = fl;
        cycle();
    endtask

    task automatic look(input logic [15:0] pc);
        op(1, pc, 0, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic train(input logic [15:0] pc, input logic [15:0] tgt, input bit tk);
        op(0, 16'h0, 1, pc, tgt, tk, 0);
    endtask

    initial begin
        int tags[6];
        int idxs[3];
        tags = '{'h040, 'h041, 'h042, 'h043, 'h044, 'h080};
        idxs = '{0, 1, 31};

        rst_n = 0; lookup_valid = 0; lookup_pc = 0; upd_valid = 0;
        upd_pc = 0; upd_target = 0; upd_taken = 0; flush = 0;
        model_clear();
        #2;
        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_target", pred_target, 16'h0000);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Cold lookup misses.
        look(16'h1000);
        check("cold_hit", pred_hit, 0);

        // Train, counter hysteresis, saturation.
        train(16'h1000, 16'h2040, 1);
        look(16'h1000);
        check("trained_target", pred_target, 16'h2040);
        train(16'h1000, 16'h0bad, 0);
        train(16'h1000, 16'h0bad, 0);
        look(16'h1000);
        check("nt_taken", pred_taken, 0);
        for (int i = 0; i < 3; i++) train(16'h1000, 16'h2040, 1);
        look(16'h1000);

        // Not-taken miss allocates nothing; taken miss allocates.
        train(16'h3000, 16'h3100, 0);
        look(16'h3000);
        train(16'h3000, 16'h3100, 1);
        look(16'h3000);

        // Fill set 0, then evict the PLRU victim (way 0).
        op(0, 16'h0, 0, 16'h0, 16'h0, 0, 1);
        train(16'h1000, 16'h5000, 1);
        train(16'h1040, 16'h5040, 1);
        train(16'h1080, 16'h5080, 1);
        train(16'h10C0, 16'h50C0, 1);
        train(16'h1100, 16'h5100, 1);
        look(16'h1000);
        check("evicted_hit", pred_hit, 0);
        look(16'h1040);
        look(16'h1100);
        check("alloc_hit", pred_hit, 1);

        // Read-before-write, then flush wins over update.
        op(0, 16'h0, 0, 16'h0, 16'h0, 0, 1);
        op(1, 16'h1000, 1, 16'h1000, 16'h6000, 1, 0);
        look(16'h1000);
        op(0, 16'h0, 1, 16'h1200, 16'h6200, 1, 1);
        look(16'h1200);
        look(16'h1000);

        // Asynchronous reset while a hit is being presented.
        train(16'h1000, 16'h7000, 1);
        look(16'h1000);
        lookup_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check("async_valid", pred_valid, 0);
        check("async_hit", pred_hit, 0);
        model_clear();
        cycle();
        @(negedge clk);
        rst_n = 1;
        #1;
        look(16'h1000);

        // Randomized traffic over a few crowded sets.
        for (int i = 0; i < 3000; i++) begin
            lookup_valid = ($urandom_range(0, 9) < 8);
            lookup_pc    = 16'((tags[$urandom_range(0, 5)] << 6) |
                               (idxs[$urandom_range(0, 2)] << 1) | $urandom_range(0, 1));
            upd_valid    = ($urandom_range(0, 9) < 7);
            upd_pc       = 16'((tags[$urandom_range(0, 5)] << 6) |
                               (idxs[$urandom_range(0, 2)] << 1) | $urandom_range(0, 1));
            upd_target   = 16'($urandom);
            upd_taken    = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
